conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 148 ++++++++++++++
 tb/tb_conv_window_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3x3 int8 sliding-window generator for a raster pixel stream.
// Two line buffers plus a 3x3 shift window feed a one-entry registered output stage.
module conv_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic           clk_i,
    input  logic           rst_n,
    input  logic [23:0]    pix_i,
    input  logic           pix_valid_i,
    output logic           pix_ready_o,
    output logic [215:0]   win_o,
    output logic           win_valid_o,
    input  logic           win_ready_i,
    output logic           frame_done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [23:0]    line1_mem [IMG_W];
    logic [23:0]    line2_mem [IMG_W];
    logic [23:0]    win_q [3][3];
    logic [23:0]    win_d [3][3];
    logic [215:0]   win_o_q, win_o_d;
    logic [215:0]   packed_s;
    logic           win_valid_q, win_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           accept_s, fire_s, last_col_s, last_row_s;

    // Handshake and position decode
    assign pix_ready_o = ~win_valid_q | win_ready_i;
    assign accept_s    = pix_valid_i & pix_ready_o;
    assign last_col_s  = (col_q == COL_LAST);
    assign last_row_s  = (row_q == ROW_LAST);
    assign fire_s      = accept_s & (row_q >= RW'(2)) & (col_q >= CW'(2));

    // Raster position counters
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept_s) begin
            if (last_col_s) begin
                col_d = {CW{1'b0}};
                if (last_row_s) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Shift window: new right column comes from the two line buffers and the incoming pixel
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = line2_mem[col_q];
            win_d[1][2] = line1_mem[col_q];
            win_d[2][2] = pix_i;
        end else begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][2];
            end
        end
    end

    // Pack the next window as byte ch*9 + wr*3 + wc
    always_comb begin
        packed_s = 216'd0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int wr = 0; wr < 3; wr++) begin
                for (int wc = 0; wc < 3; wc++) begin
                    packed_s[8*(ch*9 + wr*3 + wc) +: 8] = win_d[wr][wc][8*ch +: 8];
                end
            end
        end
    end

    // One-entry output stage and end-of-frame pulse
    always_comb begin
        win_o_d      = win_o_q;
        win_valid_d  = win_valid_q;
        frame_done_d = accept_s & last_col_s & last_row_s;
        if (fire_s) begin
            win_o_d     = packed_s;
            win_valid_d = 1'b1;
        end else if (win_ready_i) begin
            win_valid_d = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
        end
    end

    // Control, window and output registers
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            win_o_q      <= 216'd0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= 24'd0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_o_q      <= win_o_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers are plain memories; stale contents never pass the row/col gate
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            line1_mem[col_q] <= pix_i;
            line2_mem[col_q] <= line1_mem[col_q];
        end
    end

    assign win_o        = win_o_q;
    assign win_valid_o  = win_valid_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed and table-driven bench for conv_window_gen on a 4x4 frame.
module tb_conv_window_gen;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic [23:0]  pix_i;
    logic         pix_valid_i;
    logic         pix_ready_o;
    logic [215:0] win_o;
    logic         win_valid_o;
    logic         win_ready_i;
    logic         frame_done_o;

    conv_window_gen #(.IMG_W(4), .IMG_H(4)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .win_o(win_o), .win_valid_o(win_valid_o),
        .win_ready_i(win_ready_i), .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [215:0] wq[$];
    int wcyc[$];
    int fd_count = 0;
    int fd_cyc = -1;
    logic fd_with_valid = 1'b0;
    int acc_cyc[32];
    bit rand_mode = 1'b0;
    bit drv_done = 1'b0;

    // Collect every handshaken window and every frame_done pulse
    always @(negedge clk_i) begin
        if (win_valid_o && win_ready_i) begin
            wq.push_back(win_o);
            wcyc.push_back(cyc);
        end
        if (frame_done_o) begin
            fd_count = fd_count + 1;
            fd_cyc = cyc;
            fd_with_valid = win_valid_o;
        end
    end

    function automatic logic [23:0] pix(input int p);
        int t0, t1, t2;
        t0 = p; t1 = p + 16; t2 = p + 32;
        return {t2[7:0], t1[7:0], t0[7:0]};
    endfunction

    function automatic logic [215:0] exp_win(input int r, input int c);
        logic [215:0] w;
        logic [23:0] px;
        w = 216'd0;
        for (int ch = 0; ch < 3; ch++)
            for (int wr = 0; wr < 3; wr++)
                for (int wc = 0; wc < 3; wc++) begin
                    px = pix(4*(r-2+wr) + (c-2+wc));
                    w[8*(ch*9 + wr*3 + wc) +: 8] = px[8*ch +: 8];
                end
        return w;
    endfunction

    task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_mode) win_ready_i = 1'($urandom_range(1, 0));
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        bit acc;
        int waited;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) begin
                    pix_valid_i = 1'b0;
                    tick();
                end
            end
            pix_i = pix(i % 16);
            pix_valid_i = 1'b1;
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < 300) begin
                @(negedge clk_i);
                acc = pix_ready_o;
                if (acc) acc_cyc[i] = cyc + 1;
                tick();
                waited++;
            end
            if (!acc) begin
                n_checks = n_checks + 1;
                n_fail = n_fail + 1;
                $display("FAIL accept_timeout: pixel %0d never accepted", i);
                break;
            end
        end
        pix_valid_i = 1'b0;
    endtask

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        fd_count = 0;
        fd_cyc = -1;
    endtask

    task automatic drain();
        win_ready_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic check_frames(input int nframes, input string tag);
        int rs[4] = '{2, 2, 3, 3};
        int cs[4] = '{2, 3, 2, 3};
        check({tag, "_count"}, 216'(wq.size()), 216'(4*nframes));
        for (int i = 0; i < 4*nframes && i < wq.size(); i++)
            check($sformatf("%s_win%0d", tag, i), wq[i], exp_win(rs[i%4], cs[i%4]));
    endtask

    typedef struct {
        int          win;
        int          byte_idx;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs[9];

    logic [215:0] held;
    int waited;

    initial begin
        vecs[0] = '{0, 0,  8'h00};
        vecs[1] = '{0, 8,  8'h0A};
        vecs[2] = '{0, 9,  8'h10};
        vecs[3] = '{0, 26, 8'h2A};
        vecs[4] = '{1, 0,  8'h01};
        vecs[5] = '{1, 4,  8'h06};
        vecs[6] = '{1, 8,  8'h0B};
        vecs[7] = '{3, 0,  8'h05};
        vecs[8] = '{3, 8,  8'h0F};

        rst_n = 1'b1; pix_i = 24'd0; pix_valid_i = 1'b0; win_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_win_valid", 216'(win_valid_o), 216'd0);
        check("rst_win_o", win_o, 216'd0);
        check("rst_frame_done", 216'(frame_done_o), 216'd0);
        check("rst_pix_ready", 216'(pix_ready_o), 216'd1);
        @(posedge clk_i); #1;
        rst_n = 1'b0;
        tick();

        // Single frame, no stalls
        clear_log();
        send_pixels(16, 1'b0);
        drain();
        check_frames(1, "basic");
        for (int i = 0; i < 9; i++)
            if (vecs[i].win < wq.size())
                check($sformatf("byte_w%0d_b%0d", vecs[i].win, vecs[i].byte_idx),
                      216'(wq[vecs[i].win][8*vecs[i].byte_idx +: 8]), 216'(vecs[i].exp));
        if (wcyc.size() == 4) begin
            check("lat_w0", 216'(wcyc[0]), 216'(acc_cyc[10]));
            check("lat_w1", 216'(wcyc[1]), 216'(acc_cyc[11]));
            check("lat_w2", 216'(wcyc[2]), 216'(acc_cyc[14]));
            check("lat_w3", 216'(wcyc[3]), 216'(acc_cyc[15]));
        end
        check("fd_count", 216'(fd_count), 216'd1);
        check("fd_cycle", 216'(fd_cyc), 216'(acc_cyc[15]));
        check("fd_with_valid", 216'(fd_with_valid), 216'd1);

        // Consumer stall after the first window
        clear_log();
        win_ready_i = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                send_pixels(16, 1'b0);
                drv_done = 1'b1;
            end
        join_none
        repeat (40) @(posedge clk_i);
        @(negedge clk_i);
        check("stall_pix_ready", 216'(pix_ready_o), 216'd0);
        check("stall_valid", 216'(win_valid_o), 216'd1);
        check("stall_win", win_o, exp_win(2, 2));
        held = win_o;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("stall_stable", win_o, held);
        check("stall_none_taken", 216'(wq.size()), 216'd0);
        @(posedge clk_i); #1;
        win_ready_i = 1'b1;
        waited = 0;
        while (!drv_done && waited < 500) begin
            @(posedge clk_i);
            waited++;
        end
        #1;
        check("stall_driver_done", 216'(drv_done), 216'd1);
        drain();
        check_frames(1, "stall");

        // Two frames back-to-back
        clear_log();
        send_pixels(32, 1'b0);
        drain();
        check_frames(2, "two_frames");
        check("two_frames_fd", 216'(fd_count), 216'd2);

        // Reset in the middle of a frame
        clear_log();
        send_pixels(9, 1'b0);
        rst_n = 1'b1;
        @(negedge clk_i);
        check("midrst_valid", 216'(win_valid_o), 216'd0);
        check("midrst_ready", 216'(pix_ready_o), 216'd1);
        tick();
        rst_n = 1'b0;
        tick();
        clear_log();
        send_pixels(16, 1'b0);
        drain();
        check_frames(1, "midrst");
        if (wcyc.size() > 0) check("midrst_lat", 216'(wcyc[0]), 216'(acc_cyc[10]));
        check("midrst_fd", 216'(fd_count), 216'd1);

        // Random input gaps and consumer stalls
        clear_log();
        rand_mode = 1'b1;
        send_pixels(32, 1'b1);
        rand_mode = 1'b0;
        drain();
        check_frames(2, "random");
        check("random_fd", 216'(fd_count), 216'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
